// File: rtl/pga_spi_writer.sv
// SPI mode-0 write master for the AFE PGA: one 16-bit frame {CMD_BYTE, code} per accepted request.
// ready_o stays low from the cycle after acceptance until the post-frame chip-select gap has elapsed.
module pga_spi_writer #(
    parameter int          CLK_DIV  = 4,
    parameter logic [7:0]  CMD_BYTE = 8'h00,
    parameter int          GAP_HP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_i,
    input  logic       set_i,
    output logic       ready_o,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       cs_n_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_HP > 1) ? $clog2(GAP_HP) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [3:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic [15:0]   shift_reg;
    logic          tick;

    // One tick per SCLK half-period; the divider is parked at zero while idle.
    assign tick = (state != IDLE) && (div == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div       <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            shift_reg <= '0;
            ready_o   <= 1'b1;
            cs_n_o    <= 1'b1;
            sclk_o    <= 1'b0;
            mosi_o    <= 1'b0;
        end else begin
            if (state == IDLE || tick)
                div <= '0;
            else
                div <= div + 1'b1;

            case (state)
                IDLE: begin
                    if (ready_o && set_i) begin
                        shift_reg <= {CMD_BYTE, code_i};
                        state     <= SETUP;
                        ready_o   <= 1'b0;
                        cs_n_o    <= 1'b0;
                        mosi_o    <= CMD_BYTE[7];
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_o) begin
                            sclk_o <= 1'b1;
                        end else begin
                            // Data only moves on the falling edge so the slave samples a stable bit.
                            sclk_o <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt   <= bit_cnt + 1'b1;
                                shift_reg <= {shift_reg[14:0], 1'b0};
                                mosi_o    <= shift_reg[14];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_n_o  <= 1'b1;
                        mosi_o  <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt == GW'(GAP_HP - 1)) begin
                            ready_o <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
